// File: rtl/addr_alu_datapath_pkg.sv
// addr_alu_pkg: shared encodings for the 65C02 address/ALU datapath slice.
//   - ABL base/offset selects, ABH base selects, ABH carry modes
//   - ALU function and mode selects
//   - default reset value of the address bus (reset vector)
package addr_alu_pkg;

    localparam logic [15:0] RESET_AB_DEFAULT = 16'hFFFC;

    // ABL base select, abl_op[3:2]
    localparam logic [1:0] ABL_BASE_HOLD = 2'b00;
    localparam logic [1:0] ABL_BASE_PCL  = 2'b01;
    localparam logic [1:0] ABL_BASE_DBL  = 2'b10;
    localparam logic [1:0] ABL_BASE_AHL  = 2'b11;

    // ABL offset select, abl_op[1:0]
    localparam logic [1:0] ABL_OFF_ZERO  = 2'b00;
    localparam logic [1:0] ABL_OFF_REG   = 2'b01;
    localparam logic [1:0] ABL_OFF_FF    = 2'b10;
    localparam logic [1:0] ABL_OFF_ONE   = 2'b11;

    // ABH base select, abh_op
    localparam logic [1:0] ABH_BASE_HOLD = 2'b00;
    localparam logic [1:0] ABH_BASE_PCH  = 2'b01;
    localparam logic [1:0] ABH_BASE_DBL  = 2'b10;
    localparam logic [1:0] ABH_BASE_ZP   = 2'b11;

    // ABH carry-in mode, abh_cmode
    localparam logic [1:0] ABH_CI_ZERO   = 2'b00;
    localparam logic [1:0] ABH_CI_ONE    = 2'b01;
    localparam logic [1:0] ABH_CI_ABL    = 2'b10;
    localparam logic [1:0] ABH_CI_RSVD   = 2'b11;

    // ALU function, alu_op[1:0]
    localparam logic [1:0] ALU_FN_OR     = 2'b00;
    localparam logic [1:0] ALU_FN_AND    = 2'b01;
    localparam logic [1:0] ALU_FN_EOR    = 2'b10;
    localparam logic [1:0] ALU_FN_ADD    = 2'b11;

    // ALU mode, alu_op[4:3]
    localparam logic [1:0] ALU_MD_FN     = 2'b00;
    localparam logic [1:0] ALU_MD_PASS   = 2'b01;
    localparam logic [1:0] ALU_MD_SHL    = 2'b10;
    localparam logic [1:0] ALU_MD_SHR    = 2'b11;

endpackage

// File: rtl/addr_alu_datapath_if.sv
// addr_alu_datapath_if: op fields and bus signals between the microcode
// sequencer / parent CPU (master) and the address/ALU datapath (slave).
//   inputs to datapath : abl_op, abl_ci, abh_op, abh_cmode, abh_ff, pcl, pch,
//                        ahl, dbl, reg_r, alu_op, alu_ci, alu_si, alu_m
//   outputs            : ab, abl_co, alu_out, alu_co, alu_v
interface addr_alu_datapath_if;

    logic [3:0]  abl_op;
    logic        abl_ci;
    logic [1:0]  abh_op;
    logic [1:0]  abh_cmode;
    logic        abh_ff;
    logic [7:0]  pcl;
    logic [7:0]  pch;
    logic [7:0]  ahl;
    logic [7:0]  dbl;
    logic [7:0]  reg_r;
    logic [4:0]  alu_op;
    logic        alu_ci;
    logic        alu_si;
    logic [7:0]  alu_m;
    logic [15:0] ab;
    logic        abl_co;
    logic [7:0]  alu_out;
    logic        alu_co;
    logic        alu_v;

    modport master (
        output abl_op, abl_ci, abh_op, abh_cmode, abh_ff, pcl, pch, ahl, dbl,
               reg_r, alu_op, alu_ci, alu_si, alu_m,
        input  ab, abl_co, alu_out, alu_co, alu_v
    );

    modport slave (
        input  abl_op, abl_ci, abh_op, abh_cmode, abh_ff, pcl, pch, ahl, dbl,
               reg_r, alu_op, alu_ci, alu_si, alu_m,
        output ab, abl_co, alu_out, alu_co, alu_v
    );

endinterface

// File: rtl/addr_alu_datapath_alu.sv
// dp_alu: purely combinational 8-bit ALU.
//   i_op[4:0] : [4:3] mode, [2] invert M, [1:0] function
//   i_r, i_m  : R and M operands
//   i_ci      : carry in, i_si : shift in
//   o_out     : result, o_co : carry out, o_v : signed overflow (add only)
module dp_alu
    import addr_alu_pkg::*;
(
    input  logic [4:0] i_op,
    input  logic [7:0] i_r,
    input  logic [7:0] i_m,
    input  logic       i_ci,
    input  logic       i_si,
    output logic [7:0] o_out,
    output logic       o_co,
    output logic       o_v
);

    logic [7:0] w_m;
    logic [8:0] w_sum;
    logic [7:0] w_fn;
    logic       w_fn_co;
    logic       w_is_add;

    assign w_m      = i_op[2] ? ~i_m : i_m;
    assign w_sum    = {1'b0, i_r} + {1'b0, w_m} + {8'b0, i_ci};
    assign w_is_add = (i_op[4:3] == ALU_MD_FN) && (i_op[1:0] == ALU_FN_ADD);

    always_comb begin
        w_fn    = '0;
        w_fn_co = i_ci;
        case (i_op[1:0])
            ALU_FN_OR:  w_fn = i_r | w_m;
            ALU_FN_AND: w_fn = i_r & w_m;
            ALU_FN_EOR: w_fn = i_r ^ w_m;
            default: begin
                w_fn    = w_sum[7:0];
                w_fn_co = w_sum[8];
            end
        endcase
    end

    always_comb begin
        o_out = w_fn;
        o_co  = w_fn_co;
        case (i_op[4:3])
            ALU_MD_PASS: begin
                o_out = w_m;
                o_co  = i_ci;
            end
            ALU_MD_SHL: begin
                o_out = {i_r[6:0], i_si};
                o_co  = i_r[7];
            end
            ALU_MD_SHR: begin
                o_out = {i_si, i_r[7:1]};
                o_co  = i_r[0];
            end
            default: ;
        endcase
    end

    // Operands share a sign but the result sign differs from it.
    assign o_v = w_is_add && (i_r[7] == w_m[7]) && (w_sum[7] != i_r[7]);

endmodule

// File: rtl/addr_alu_datapath.sv
// addr_alu_datapath: registered 16-bit address bus (ABL/ABH with low-to-high
// carry) plus the combinational ALU.
//   clk : rising-edge clock
//   RST : synchronous active-high reset, loads RESET_AB into ab
//   bus : addr_alu_datapath_if.slave, op fields in, ab/abl_co/ALU results out
module addr_alu_datapath
    import addr_alu_pkg::*;
#(
    parameter logic [15:0] RESET_AB = RESET_AB_DEFAULT
) (
    input  logic               clk,
    input  logic               RST,
    addr_alu_datapath_if.slave bus
);

    logic [7:0] r_abl;
    logic [7:0] r_abh;
    logic [7:0] w_abl_base;
    logic [7:0] w_abl_off;
    logic [8:0] w_abl_sum;
    logic [7:0] w_abh_base;
    logic       w_abh_ci;
    logic [7:0] w_abh_next;

    always_comb begin
        w_abl_base = r_abl;
        case (bus.abl_op[3:2])
            ABL_BASE_PCL: w_abl_base = bus.pcl;
            ABL_BASE_DBL: w_abl_base = bus.dbl;
            ABL_BASE_AHL: w_abl_base = bus.ahl;
            default:      w_abl_base = r_abl;
        endcase
    end

    always_comb begin
        w_abl_off = 8'h00;
        case (bus.abl_op[1:0])
            ABL_OFF_REG: w_abl_off = bus.reg_r;
            ABL_OFF_FF:  w_abl_off = 8'hFF;
            ABL_OFF_ONE: w_abl_off = 8'h01;
            default:     w_abl_off = 8'h00;
        endcase
    end

    assign w_abl_sum = {1'b0, w_abl_base} + {1'b0, w_abl_off} + {8'b0, bus.abl_ci};

    always_comb begin
        w_abh_base = r_abh;
        case (bus.abh_op)
            ABH_BASE_PCH: w_abh_base = bus.pch;
            ABH_BASE_DBL: w_abh_base = bus.dbl;
            ABH_BASE_ZP:  w_abh_base = 8'h00;
            default:      w_abh_base = r_abh;
        endcase
    end

    always_comb begin
        w_abh_ci = 1'b0;
        case (bus.abh_cmode)
            ABH_CI_ONE: w_abh_ci = 1'b1;
            ABH_CI_ABL: w_abh_ci = w_abl_sum[8];
            default:    w_abh_ci = 1'b0;
        endcase
    end

    // 8-bit wrap: a carry out of ABH is intentionally dropped.
    assign w_abh_next = w_abh_base + {7'b0, w_abh_ci};

    always_ff @(posedge clk) begin
        if (RST) begin
            r_abl <= RESET_AB[7:0];
            r_abh <= RESET_AB[15:8];
        end else begin
            r_abl <= w_abl_sum[7:0];
            r_abh <= bus.abh_ff ? 8'hFF : w_abh_next;
        end
    end

    assign bus.ab     = {r_abh, r_abl};
    assign bus.abl_co = w_abl_sum[8];

    dp_alu u_alu (
        .i_op  (bus.alu_op),
        .i_r   (bus.reg_r),
        .i_m   (bus.alu_m),
        .i_ci  (bus.alu_ci),
        .i_si  (bus.alu_si),
        .o_out (bus.alu_out),
        .o_co  (bus.alu_co),
        .o_v   (bus.alu_v)
    );

endmodule

// File: tb/tb_addr_alu_datapath.sv
module tb_addr_alu_datapath;

    logic clk;
    logic RST;
    int   errors;
    int   checks;

    addr_alu_datapath_if bus ();

    addr_alu_datapath #(.RESET_AB(16'hFFFC)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_ops();
        bus.abl_op = 4'b0000; bus.abl_ci = 1'b0; bus.abh_op = 2'b00;
        bus.abh_cmode = 2'b00; bus.abh_ff = 1'b0;
        bus.pcl = 8'h00; bus.pch = 8'h00; bus.ahl = 8'h00; bus.dbl = 8'h00;
        bus.reg_r = 8'h00; bus.alu_op = 5'b00000; bus.alu_ci = 1'b0;
        bus.alu_si = 1'b0; bus.alu_m = 8'h00;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_ops();
        bus.abl_op = 4'b0111; bus.abh_op = 2'b01; bus.abh_ff = 1'b1;
        bus.pcl = 8'h33; bus.pch = 8'h44;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (bus.ab !== 16'hFFFC) begin
            errors++;
            $display("FAIL reset_ab: got %h expected %h", bus.ab, 16'hFFFC);
        end
    endtask

    task automatic test_pc_fetch();
        clear_ops();
        bus.abl_op = 4'b0111; bus.abh_op = 2'b01; bus.abh_cmode = 2'b10;
        bus.pch = 8'h12; bus.pcl = 8'hFF;
        #1;
        checks++;
        if (bus.abl_co !== 1'b1) begin
            errors++;
            $display("FAIL pc_fetch_abl_co: got %b expected %b", bus.abl_co, 1'b1);
        end
        tick();
        checks++;
        if (bus.ab !== 16'h1300) begin
            errors++;
            $display("FAIL pc_fetch_ab: got %h expected %h", bus.ab, 16'h1300);
        end
    endtask

    task automatic test_indexed_zp();
        clear_ops();
        bus.abl_op = 4'b1001; bus.dbl = 8'hF0; bus.reg_r = 8'h20;
        bus.abh_op = 2'b11; bus.abh_cmode = 2'b00;
        tick();
        checks++;
        if (bus.ab !== 16'h0010) begin
            errors++;
            $display("FAIL zp_index_ab: got %h expected %h", bus.ab, 16'h0010);
        end
        bus.abh_op = 2'b10; bus.abh_cmode = 2'b10;
        tick();
        checks++;
        if (bus.ab !== 16'hF110) begin
            errors++;
            $display("FAIL abs_index_ab: got %h expected %h", bus.ab, 16'hF110);
        end
    endtask

    task automatic test_vector_hold();
        clear_ops();
        bus.abh_ff = 1'b1; bus.abh_op = 2'b01; bus.pch = 8'h77;
        bus.abh_cmode = 2'b01;
        tick();
        checks++;
        if (bus.ab !== 16'hFF10) begin
            errors++;
            $display("FAIL vector_ab: got %h expected %h", bus.ab, 16'hFF10);
        end
        clear_ops();
        tick();
        checks++;
        if (bus.ab !== 16'hFF10) begin
            errors++;
            $display("FAIL hold_ab: got %h expected %h", bus.ab, 16'hFF10);
        end
    endtask

    task automatic test_wrap();
        // ABH FF + 1 wraps to 00; ABL holds 10 with no carry.
        clear_ops();
        bus.abh_cmode = 2'b01;
        #1;
        checks++;
        if (bus.abl_co !== 1'b0) begin
            errors++;
            $display("FAIL hold_abl_co: got %b expected %b", bus.abl_co, 1'b0);
        end
        tick();
        checks++;
        if (bus.ab !== 16'h0010) begin
            errors++;
            $display("FAIL abh_wrap_ab: got %h expected %h", bus.ab, 16'h0010);
        end
        // AHL + FF offset: 05 + FF = 104 -> ABL 04, carry dropped by cmode 11.
        clear_ops();
        bus.abl_op = 4'b1110; bus.ahl = 8'h05;
        bus.abh_op = 2'b01; bus.pch = 8'h12; bus.abh_cmode = 2'b11;
        #1;
        checks++;
        if (bus.abl_co !== 1'b1) begin
            errors++;
            $display("FAIL ahl_ff_abl_co: got %b expected %b", bus.abl_co, 1'b1);
        end
        tick();
        checks++;
        if (bus.ab !== 16'h1204) begin
            errors++;
            $display("FAIL cmode_rsvd_ab: got %h expected %h", bus.ab, 16'h1204);
        end
        // RST beats abh_ff.
        bus.abh_ff = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (bus.ab !== 16'hFFFC) begin
            errors++;
            $display("FAIL rst_over_ff_ab: got %h expected %h", bus.ab, 16'hFFFC);
        end
    endtask

    task automatic test_alu_arith();
        clear_ops();
        bus.reg_r = 8'h7F; bus.alu_m = 8'h01; bus.alu_ci = 1'b0; bus.alu_op = 5'b00011;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co, bus.alu_v} !== {8'h80, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL adc: got out=%h co=%b v=%b expected out=80 co=0 v=1",
                     bus.alu_out, bus.alu_co, bus.alu_v);
        end
        bus.reg_r = 8'h05; bus.alu_m = 8'h06; bus.alu_ci = 1'b1; bus.alu_op = 5'b00111;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co, bus.alu_v} !== {8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sbc: got out=%h co=%b v=%b expected out=ff co=0 v=0",
                     bus.alu_out, bus.alu_co, bus.alu_v);
        end
        // 80 + 80 -> 00, carry 1, overflow 1.
        bus.reg_r = 8'h80; bus.alu_m = 8'h80; bus.alu_ci = 1'b0; bus.alu_op = 5'b00011;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co, bus.alu_v} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL adc_neg: got out=%h co=%b v=%b expected out=00 co=1 v=1",
                     bus.alu_out, bus.alu_co, bus.alu_v);
        end
    endtask

    task automatic test_alu_logic_shift();
        clear_ops();
        bus.reg_r = 8'hF0; bus.alu_m = 8'h3C; bus.alu_ci = 1'b1; bus.alu_op = 5'b00001;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co, bus.alu_v} !== {8'h30, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL and: got out=%h co=%b v=%b expected out=30 co=1 v=0",
                     bus.alu_out, bus.alu_co, bus.alu_v);
        end
        bus.alu_op = 5'b00000;
        #1;
        checks++;
        if (bus.alu_out !== 8'hFC) begin
            errors++;
            $display("FAIL ora: got %h expected %h", bus.alu_out, 8'hFC);
        end
        bus.alu_op = 5'b00010; bus.alu_ci = 1'b0;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co} !== {8'hCC, 1'b0}) begin
            errors++;
            $display("FAIL eor: got out=%h co=%b expected out=cc co=0", bus.alu_out, bus.alu_co);
        end
        bus.reg_r = 8'h81; bus.alu_si = 1'b1; bus.alu_op = 5'b10000;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co, bus.alu_v} !== {8'h03, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rol: got out=%h co=%b v=%b expected out=03 co=1 v=0",
                     bus.alu_out, bus.alu_co, bus.alu_v);
        end
        bus.reg_r = 8'h01; bus.alu_si = 1'b1; bus.alu_op = 5'b11000;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co} !== {8'h80, 1'b1}) begin
            errors++;
            $display("FAIL ror: got out=%h co=%b expected out=80 co=1", bus.alu_out, bus.alu_co);
        end
        bus.reg_r = 8'h11; bus.alu_m = 8'h5A; bus.alu_ci = 1'b0; bus.alu_op = 5'b01000;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co} !== {8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL pass_m: got out=%h co=%b expected out=5a co=0", bus.alu_out, bus.alu_co);
        end
        bus.alu_op = 5'b01100; bus.alu_ci = 1'b1;
        #1;
        checks++;
        if ({bus.alu_out, bus.alu_co} !== {8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL pass_notm: got out=%h co=%b expected out=a5 co=1", bus.alu_out, bus.alu_co);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST = 1'b0;
        clear_ops();
        @(negedge clk);
        test_reset();
        test_pc_fetch();
        test_indexed_zp();
        test_vector_hold();
        test_wrap();
        test_alu_arith();
        test_alu_logic_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addr_alu_datapath.md
Name: addr_alu_datapath

Overview:
Combined datapath slice for the microcoded 65C02 core. It holds three parts:
- the registered 16-bit address bus (ABL and ABH halves, with a carry path from low to high);
- the combinational 8-bit ALU that computes register/memory results;
- the carry out of each.

The microcode sequencer drives all op fields. PC, AHL and the register file are owned by the parent CPU.

Parameters:
RESET_AB, 16'hFFFC, address bus value loaded on reset (65C02 reset vector).

Ports:
clk  in  1  clock, all registers update on rising edge
RST  in  1  synchronous active-high reset
abl_op  in  4  [3:2] ABL base select, [1:0] ABL offset select
abl_ci  in  1  ABL adder carry in
abh_op  in  2  ABH base select
abh_cmode  in  2  ABH carry in: 00=0, 01=1, 10=abl_co, 11=0
abh_ff  in  1  force ABH to 8'hFF (vector page)
pcl  in  8  PC low byte
pch  in  8  PC high byte
ahl  in  8  address hold low
dbl  in  8  data bus input
reg_r  in  8  register-file read value (shared by ABL offset and ALU R operand)
alu_op  in  5  ALU operation
alu_ci  in  1  ALU carry in
alu_si  in  1  ALU shift in
alu_m  in  8  ALU M operand (registered memory byte)
ab  out  16  {ABH, ABL}, registered
abl_co  out  1  combinational carry out of the ABL adder
alu_out  out  8  combinational ALU result
alu_co  out  1  combinational ALU carry out
alu_v  out  1  combinational signed overflow from the ALU add

Behaviour:
- Reset:
  - RST high at an edge: ab <= RESET_AB, overriding every op.
  - The ALU outputs are combinational and unaffected by reset.
- ABL base (abl_op[3:2]): 00 current ABL (hold), 01 pcl, 10 dbl, 11 ahl.
- ABL offset (abl_op[1:0]): 00 8'h00, 01 reg_r, 10 8'hFF, 11 8'h01.
- ABL update: {abl_co, sum} = base + offset + abl_ci, as a 9-bit sum. ABL <= sum[7:0] every cycle.
  - abl_co is combinational from the current cycle's operands.
- ABH base (abh_op): 00 current ABH, 01 pch, 10 dbl, 11 8'h00 (zero page).
- ABH update: ABH <= base + carry, 8-bit wrap, where carry is chosen by abh_cmode.
  - abh_cmode=10 uses abl_co from the same cycle, giving a single-cycle 16-bit add.
- abh_ff=1 gives ABH <= 8'hFF. Priority is RST > abh_ff > normal. abh_ff does not affect ABL.
- Wrap-around: ABL FF+01 gives 00 with abl_co=1. ABH FF+1 gives 00 with no carry out (16-bit wrap).
- ALU function:
  - alu_op[2]=1 replaces M with ~M (used for SBC/CMP).
  - alu_op[1:0] selects the function on R=reg_r and M': 00 R|M', 01 R&M', 10 R^M', 11 R+M'+ci.
  - alu_op[4:3] selects the mode:
    - 00 function result.
    - 01 pass M' (OUT=M', co=ci).
    - 10 shift left: OUT={R[6:0],si}, co=R[7].
    - 11 shift right: OUT={si,R[7:1]}, co=R[0].
  - Logic functions: alu_co = alu_ci.
  - Add: alu_co = bit 8 of the sum. alu_v = (R[7]==M'[7]) && (OUT[7]!=R[7]). alu_v=0 when not in add mode.
- Latency: ab changes one cycle after its op is applied. ALU and abl_co have 0 latency.
- X or reserved inputs are not checked. Encoding 11 of abh_cmode gives carry 0.

Decomposition:
- Package addr_alu_pkg holds:
  - localparams for the ABL base/offset encodings, ABH base encodings and abh_cmode values;
  - ALU function and mode encodings;
  - RESET_AB default.
- One natural sub-module: dp_alu (pure combinational ALU).
- ABL and ABH stay inline in the top module.

Test Plan:
- Reset: RST=1 for one edge with arbitrary ops -> ab=16'hFFFC.
- PC fetch: abl_op={01,11}, abl_ci=0, abh_op=01, abh_cmode=10, pch=12, pcl=FF -> next ab=16'h1300, abl_co=1 during the cycle.
- Indexed zero page: abl_op={10,01}, dbl=F0, reg_r=20, abh_op=11, abh_cmode=00 -> ab=16'h0010. Same with abh_cmode=10 and abh_op=10, dbl reused as F0 -> ab=16'hF110.
- Vector and hold: abh_ff=1, abl_op={00,00} -> ABH=FF and ABL unchanged. With RST=0 and abh_ff=0, ab holds on the next cycle.
- ALU add and subtract:
  - ADC R=7F, M=01, ci=0, op=00011 -> out=80, co=0, v=1.
  - SBC R=05, M=06, ci=1, op=00111 -> out=FF, co=0.
- ALU logic and shift:
  - AND R=F0, M=3C -> 30, co=ci.
  - ROL R=81, si=1 (op 10xxx) -> out=03, co=1.
  - ROR R=01, si=1 (op 11xxx) -> out=80, co=1.
  - Pass M (op 01000) M=5A -> out=5A.
